// File: rtl/conv3x3_filter_if.sv
// conv3x3_filter_if: upstream pixel pop interface plus downstream valid/ready output
interface conv3x3_filter_if;
    logic [7:0] i_pix_data;
    logic       i_pix_valid;
    logic       o_pix_next;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    modport slave  (input  i_pix_data, i_pix_valid, i_ready, output o_pix_next, o_data, o_valid);
    modport master (output i_pix_data, i_pix_valid, i_ready, input  o_pix_next, o_data, o_valid);
endinterface

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: streaming 3x3 filter (pass/blur/sobel/sharpen) with two line buffers
module conv3x3_filter #(
    parameter int IMG_W = 225,
    parameter int IMG_H = 225
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vsync,
    input  logic [1:0]       i_mode,
    conv3x3_filter_if.slave  bus,
    output logic             o_frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_mode;
    logic [CW-1:0]         r_in_col, r_iss_col, r_s1_col, r_out_col;
    logic [RW-1:0]         r_in_row, r_iss_row, r_s1_row, r_out_row;
    logic [7:0]            r_lb0 [IMG_W];
    logic [7:0]            r_lb1 [IMG_W];
    logic [2:0][2:0][7:0]  r_win;
    logic                  r_s1_valid;
    logic                  r_valid;
    logic [7:0]            r_data;

    logic                  w_go, w_pop, w_adv, w_issue, w_stall;
    logic                  w_accept, w_last_acc, w_in_row1, w_in_last;
    logic [7:0]            w_pix;
    logic [11:0]           w_gsum;
    logic [7:0]            w_blur;
    logic [9:0]            w_xp, w_xn, w_yp, w_yn;
    logic signed [10:0]    w_gx, w_gy;
    logic [10:0]           w_ax, w_ay;
    logic [11:0]           w_mag;
    logic [10:0]           w_c5;
    logic [9:0]            w_s4;
    logic signed [11:0]    w_sh;
    logic                  w_border;
    logic [7:0]            w_result;

    assign bus.o_pix_next = w_pop;
    assign bus.o_data     = r_data;
    assign bus.o_valid    = r_valid;

    // handshake decode: pops, window advances and output issue for the current state
    always_comb begin
        w_stall    = r_valid & ~bus.i_ready;
        w_go       = i_vsync & ~w_stall;
        w_pop      = w_go & bus.i_pix_valid & (r_state == S_PRIME || r_state == S_RUN);
        w_adv      = w_pop | (w_go & (r_state == S_FLUSH));
        w_issue    = w_adv & (r_state != S_PRIME);
        w_pix      = (r_state == S_FLUSH) ? 8'd0 : bus.i_pix_data;
        w_accept   = r_valid & bus.i_ready;
        w_last_acc = w_accept & (r_out_row == LAST_ROW) & (r_out_col == LAST_COL);
        w_in_row1  = (r_in_row == RW'(1)) & (r_in_col == '0);
        w_in_last  = (r_in_row == LAST_ROW) & (r_in_col == LAST_COL);
    end

    // next-state: prime one line plus one pixel, stream, flush the same amount, drain
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_PRIME;
            S_PRIME: w_next = (w_adv && w_in_row1) ? S_RUN : S_PRIME;
            S_RUN:   w_next = (w_adv && w_in_last) ? S_FLUSH : S_RUN;
            S_FLUSH: w_next = (w_adv && w_in_row1) ? S_DONE : S_FLUSH;
            S_DONE:  w_next = w_last_acc ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // state register; a low vsync restarts the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= i_vsync ? w_next : S_IDLE;
    end

    // kernel arithmetic on the stage-1 window, borders pass the centre through
    always_comb begin
        w_gsum   = {4'd0, r_win[0][0]} + {3'd0, r_win[0][1], 1'b0} + {4'd0, r_win[0][2]}
                 + {3'd0, r_win[1][0], 1'b0} + {2'd0, r_win[1][1], 2'b0} + {3'd0, r_win[1][2], 1'b0}
                 + {4'd0, r_win[2][0]} + {3'd0, r_win[2][1], 1'b0} + {4'd0, r_win[2][2]};
        w_blur   = 8'(w_gsum >> 4);
        w_xp     = {2'd0, r_win[0][2]} + {1'd0, r_win[1][2], 1'b0} + {2'd0, r_win[2][2]};
        w_xn     = {2'd0, r_win[0][0]} + {1'd0, r_win[1][0], 1'b0} + {2'd0, r_win[2][0]};
        w_yp     = {2'd0, r_win[2][0]} + {1'd0, r_win[2][1], 1'b0} + {2'd0, r_win[2][2]};
        w_yn     = {2'd0, r_win[0][0]} + {1'd0, r_win[0][1], 1'b0} + {2'd0, r_win[0][2]};
        w_gx     = $signed({1'b0, w_xp}) - $signed({1'b0, w_xn});
        w_gy     = $signed({1'b0, w_yp}) - $signed({1'b0, w_yn});
        w_ax     = w_gx[10] ? -w_gx : w_gx;
        w_ay     = w_gy[10] ? -w_gy : w_gy;
        w_mag    = {1'b0, w_ax} + {1'b0, w_ay};
        w_c5     = {1'b0, r_win[1][1], 2'b0} + {3'd0, r_win[1][1]};
        w_s4     = {2'd0, r_win[0][1]} + {2'd0, r_win[1][0]} + {2'd0, r_win[1][2]} + {2'd0, r_win[2][1]};
        w_sh     = $signed({1'b0, w_c5}) - $signed({2'd0, w_s4});
        w_border = (r_s1_row == '0) || (r_s1_row == LAST_ROW) || (r_s1_col == '0) || (r_s1_col == LAST_COL);
        w_result = (w_border || r_mode == 2'b00) ? r_win[1][1] :
                   (r_mode == 2'b01) ? w_blur :
                   (r_mode == 2'b10) ? ((|w_mag[11:8]) ? 8'hff : w_mag[7:0]) :
                   w_sh[11] ? 8'h00 : ((|w_sh[10:8]) ? 8'hff : w_sh[7:0]);
    end

    // line buffers and window shift; contents only matter once a frame has primed
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_lb0[r_in_col] <= w_pix;
            r_lb1[r_in_col] <= r_lb0[r_in_col];
            r_win[0]        <= {r_lb1[r_in_col], r_win[0][2:1]};
            r_win[1]        <= {r_lb0[r_in_col], r_win[1][2:1]};
            r_win[2]        <= {w_pix, r_win[2][2:1]};
        end
    end

    // frame counters, two-stage output pipeline, mode latch and frame-done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= '0;
            r_in_col     <= '0;
            r_in_row     <= '0;
            r_iss_col    <= '0;
            r_iss_row    <= '0;
            r_s1_col     <= '0;
            r_s1_row     <= '0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_s1_valid   <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            o_frame_done <= 1'b0;
        end else if (!i_vsync || r_state == S_IDLE) begin
            r_mode       <= i_mode;
            r_in_col     <= '0;
            r_in_row     <= '0;
            r_iss_col    <= '0;
            r_iss_row    <= '0;
            r_s1_col     <= '0;
            r_s1_row     <= '0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_s1_valid   <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= (r_state == S_DONE) && w_last_acc;
            if (w_adv) begin
                r_in_col <= (r_in_col == LAST_COL) ? '0 : r_in_col + 1'b1;
                if (r_in_col == LAST_COL)
                    r_in_row <= (r_in_row == LAST_ROW) ? '0 : r_in_row + 1'b1;
            end
            if (w_issue) begin
                r_s1_col  <= r_iss_col;
                r_s1_row  <= r_iss_row;
                r_iss_col <= (r_iss_col == LAST_COL) ? '0 : r_iss_col + 1'b1;
                if (r_iss_col == LAST_COL)
                    r_iss_row <= (r_iss_row == LAST_ROW) ? '0 : r_iss_row + 1'b1;
            end
            if (w_accept) begin
                r_out_col <= (r_out_col == LAST_COL) ? '0 : r_out_col + 1'b1;
                if (r_out_col == LAST_COL)
                    r_out_row <= (r_out_row == LAST_ROW) ? '0 : r_out_row + 1'b1;
            end
            if (!w_stall) begin
                r_s1_valid <= w_issue;
                r_valid    <= r_s1_valid;
                if (r_s1_valid)
                    r_data <= w_result;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_filter.sv
// tb_conv3x3_filter: directed frames on a small image checked against hand values and a window model
module tb_conv3x3_filter;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_vsync = 1'b1;
    logic [1:0] i_mode = 2'b00;
    logic       o_frame_done;
    logic [7:0] img [N];
    logic [7:0] got [N];
    int         n_checks = 0;
    int         n_errors = 0;

    conv3x3_filter_if bus();

    conv3x3_filter #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_vsync      (i_vsync),
        .i_mode       (i_mode),
        .bus          (bus),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int px(input int r, input int c);
        return int'(img[r * W + c]);
    endfunction

    function automatic logic [7:0] gold(input int m, input int r, input int c);
        int s, gx, gy;
        if (m == 0 || r == 0 || r == H - 1 || c == 0 || c == W - 1)
            return img[r * W + c];
        if (m == 1) begin
            s = px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1) + 2*px(r,c-1) + 4*px(r,c)
              + 2*px(r,c+1) + px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1);
            return 8'(s / 16);
        end
        if (m == 2) begin
            gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
            gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
            s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            return (s > 255) ? 8'd255 : 8'(s);
        end
        s = 5*px(r,c) - px(r-1,c) - px(r,c-1) - px(r,c+1) - px(r+1,c);
        return (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
    endfunction

    // one frame: m = kernel, rnd_rdy = random backpressure, gap_at = pixel index for a 20-cycle
    // upstream gap (-1 none), vs_at = output count that triggers a vsync abort (0 none)
    task automatic run_frame(input int m, input bit rnd_rdy, input int gap_at, input int vs_at);
        int         ptr = 0;
        int         oi = 0;
        int         cyc = 0;
        int         dones = 0;
        int         gap_left = 0;
        int         burst = 0;
        int         vs_state = 0;
        bit         gap_done = 1'b0;
        bit         in_gap = 1'b0;
        bit         prev_stall = 1'b0;
        bit         last_prev = 1'b0;
        bit         fin = 1'b0;
        logic [7:0] prev_data = 8'd0;
        i_mode = 2'(m);
        while (!fin && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 20)
                i_mode = 2'(m ^ 3);
            if (vs_state == 1) begin
                i_vsync  = 1'b0;
                vs_state = 2;
            end else if (vs_state == 2) begin
                i_vsync  = 1'b1;
                vs_state = 3;
            end
            if (gap_left == 0 && !gap_done && ptr == gap_at) begin
                gap_left = 20;
                gap_done = 1'b1;
            end
            in_gap = (gap_left > 0);
            if (in_gap)
                gap_left--;
            bus.i_pix_valid = (ptr < N) && !in_gap;
            bus.i_pix_data  = bus.i_pix_valid ? img[ptr] : 8'h5a;
            if (!rnd_rdy)
                bus.i_ready = 1'b1;
            else if (burst > 0) begin
                bus.i_ready = 1'b0;
                burst--;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_ready = 1'b0;
                burst = 9;
            end else
                bus.i_ready = 1'($urandom_range(0, 1));
            #1;
            if (vs_state == 3) begin
                check("vsync_valid", bus.o_valid, 0);
                check("vsync_done", o_frame_done, 0);
                fin = 1'b1;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_data", bus.o_data, prev_data);
                    check("stall_hold_valid", bus.o_valid, 1);
                end
                if (bus.o_valid && !bus.i_ready)
                    check("stall_pop", bus.o_pix_next, 0);
                if (in_gap)
                    check("gap_pop", bus.o_pix_next, 0);
                if (o_frame_done) begin
                    dones++;
                    check("done_timing", last_prev, 1);
                    fin = 1'b1;
                end
                last_prev = 1'b0;
                if (bus.o_pix_next)
                    ptr++;
                if (bus.o_valid && bus.i_ready) begin
                    if (oi < N) begin
                        got[oi] = bus.o_data;
                        check($sformatf("pix m%0d r%0d c%0d", m, oi / W, oi % W), bus.o_data, gold(m, oi / W, oi % W));
                    end else
                        check("extra_output", oi, N - 1);
                    last_prev = (oi == N - 1);
                    oi++;
                    if (vs_at > 0 && oi == vs_at)
                        vs_state = 1;
                end
                prev_stall = bus.o_valid && !bus.i_ready;
                prev_data  = bus.o_data;
            end
        end
        if (vs_at == 0) begin
            check("out_count", oi, N);
            check("done_count", dones, 1);
            check("pop_count", ptr, N);
        end else
            check("vsync_reached", vs_state, 3);
        bus.i_ready = 1'b1;
    endtask

    initial begin
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = 8'd77;
        bus.i_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", bus.o_valid, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_pop", bus.o_pix_next, 0);
        check("rst_done", o_frame_done, 0);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) img[i] = 8'd100;
        for (int m = 0; m < 4; m++) begin
            run_frame(m, 1'b0, -1, 0);
            check($sformatf("const m%0d interior", m), got[2*W+2], (m == 2) ? 0 : 100);
            check($sformatf("const m%0d corner", m), got[0], 100);
        end

        for (int i = 0; i < N; i++) img[i] = 8'(i % W);
        run_frame(2, 1'b0, -1, 0);
        check("ramp interior", got[2*W+3], 8);
        check("ramp top border", got[5], 5);
        check("ramp right border", got[3*W+7], 7);

        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[3*W+3] = 8'd255;
        run_frame(3, 1'b0, -1, 0);
        check("sharpen centre", got[3*W+3], 255);
        check("sharpen above", got[2*W+3], 0);
        run_frame(1, 1'b0, -1, 0);
        check("blur centre", got[3*W+3], 63);
        check("blur right", got[3*W+4], 31);
        check("blur diag", got[4*W+4], 15);

        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(3, 1'b1, -1, 0);

        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(1, 1'b0, 21, 0);

        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(2, 1'b1, -1, 30);
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(3, 1'b0, -1, 0);
        run_frame(2, 1'b1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
